// File: rtl/vga_timing_receiver_pkg.sv
// Shared state encoding, default timing constants and counter helpers
// for the VGA timing receiver.
package vga_timing_receiver_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_e;

  localparam int DEF_H_SYNC_CYC  = 96;
  localparam int DEF_H_SYNC_BACK = 48;
  localparam int DEF_H_SYNC_ACT  = 640;
  localparam int DEF_V_SYNC_CYC  = 2;
  localparam int DEF_V_SYNC_BACK = 32;
  localparam int DEF_V_SYNC_ACT  = 480;
  localparam int DEF_H_PERIOD    = 801;
  localparam int DEF_V_PERIOD    = 526;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and flags its falling edge.
// History resets high so no edge is reported on the first cycle after reset.
module vga_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_i;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA sink: measures line/frame periods, locks to the expected timing and
// recovers active-area coordinates and qualified pixels (2-clock latency).
module vga_timing_receiver
  import vga_timing_receiver_pkg::*;
#(
  parameter int H_SYNC_CYC  = DEF_H_SYNC_CYC,
  parameter int H_SYNC_BACK = DEF_H_SYNC_BACK,
  parameter int H_SYNC_ACT  = DEF_H_SYNC_ACT,
  parameter int V_SYNC_CYC  = DEF_V_SYNC_CYC,
  parameter int V_SYNC_BACK = DEF_V_SYNC_BACK,
  parameter int V_SYNC_ACT  = DEF_V_SYNC_ACT,
  parameter int H_PERIOD    = DEF_H_PERIOD,
  parameter int V_PERIOD    = DEF_V_PERIOD,
  parameter int H_TOL       = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iVGA_H_SYNC,
  input  logic        iVGA_V_SYNC,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic [9:0]  oCoord_X,
  output logic [9:0]  oCoord_Y,
  output logic        oPix_Valid,
  output logic [9:0]  oR,
  output logic [9:0]  oG,
  output logic [9:0]  oB,
  output logic        oFrame_Start,
  output logic        oLocked,
  output logic        oErr,
  output logic [10:0] oLine_Period,
  output logic [10:0] oFrame_Lines,
  output logic [1:0]  oDbg_State
);

  localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC_CYC + H_SYNC_BACK);
  localparam logic [10:0] H_ACT_END = 11'(H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC_CYC + V_SYNC_BACK);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT);
  localparam logic [10:0] H_MIN     = 11'(H_PERIOD - H_TOL);
  localparam logic [10:0] H_MAX     = 11'(H_PERIOD + H_TOL);
  localparam logic [10:0] V_PER     = 11'(V_PERIOD);
  localparam logic [2:0]  LOCK_N    = 3'(LOCK_FRAMES);

  logic        h_fall, v_fall;
  logic [29:0] rgb_q;

  rx_state_e   state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        first_h_q, first_h_d;
  logic        line_bad_q, line_bad_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0] line_period, frame_lines;
  logic        line_fail, frame_ok, active;

  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        fs_q, fs_d, err_q, err_d;
  logic [10:0] line_per_q, line_per_d, frame_lines_q, frame_lines_d;

  vga_sync_edge u_h_edge (.clk_i(iCLK), .rst_i(iRST), .sync_i(iVGA_H_SYNC), .fall_o(h_fall));
  vga_sync_edge u_v_edge (.clk_i(iCLK), .rst_i(iRST), .sync_i(iVGA_V_SYNC), .fall_o(v_fall));

  // h_cnt_d/v_cnt_d are the position of the pixel currently in the input register.
  always_comb begin
    h_cnt_d     = h_fall ? '0 : sat_inc(h_cnt_q);
    v_cnt_d     = v_fall ? '0 : (h_fall ? sat_inc(v_cnt_q) : v_cnt_q);
    line_period = sat_inc(h_cnt_q);
    frame_lines = sat_inc(v_cnt_q);
    line_fail   = h_fall && !first_h_q && ((line_period < H_MIN) || (line_period > H_MAX));
    // A failing line that ends exactly at vfall still belongs to the ending frame.
    frame_ok    = (frame_lines == V_PER) && !line_bad_q && !line_fail;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (v_fall) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        if (v_fall) begin
          if (frame_ok) begin
            good_d = good_q + 3'd1;
            if (good_q + 3'd1 == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        // oErr is shown for one cycle while still locked, then lock drops.
        if (err_q) state_d = ST_SEARCH;
        else if (line_fail || (v_fall && !frame_ok) || (v_cnt_q == CNT_MAX)) err_d = 1'b1;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    first_h_d = first_h_q;
    if (state_q != ST_SEARCH && state_d == ST_SEARCH) first_h_d = 1'b1;
    else if (h_fall) first_h_d = 1'b0;
    line_bad_d = v_fall ? 1'b0 : (line_bad_q | line_fail);

    active = (state_q == ST_LOCKED)
          && (h_cnt_d >= H_ACT_BEG) && (h_cnt_d < H_ACT_END)
          && (v_cnt_d >= V_ACT_BEG) && (v_cnt_d < V_ACT_END);

    pix_valid_d   = active;
    x_d           = active ? (h_cnt_d[9:0] - H_ACT_BEG[9:0]) : x_q;
    y_d           = active ? (v_cnt_d[9:0] - V_ACT_BEG[9:0]) : y_q;
    r_d           = active ? rgb_q[29:20] : '0;
    g_d           = active ? rgb_q[19:10] : '0;
    b_d           = active ? rgb_q[9:0]   : '0;
    fs_d          = v_fall && (state_q == ST_LOCKED);
    line_per_d    = h_fall ? line_period : line_per_q;
    frame_lines_d = v_fall ? frame_lines : frame_lines_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      first_h_q     <= 1'b1;
      line_bad_q    <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= '0;
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      fs_q          <= 1'b0;
      err_q         <= 1'b0;
      line_per_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      first_h_q     <= first_h_d;
      line_bad_q    <= line_bad_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= {iVGA_R, iVGA_G, iVGA_B};
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      fs_q          <= fs_d;
      err_q         <= err_d;
      line_per_q    <= line_per_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign oCoord_X     = x_q;
  assign oCoord_Y     = y_q;
  assign oPix_Valid   = pix_valid_q;
  assign oR           = r_q;
  assign oG           = g_q;
  assign oB           = b_q;
  assign oFrame_Start = fs_q;
  assign oLocked      = (state_q == ST_LOCKED);
  assign oErr         = err_q;
  assign oLine_Period = line_per_q;
  assign oFrame_Lines = frame_lines_q;
  assign oDbg_State   = state_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a scaled-down raster
// (20 clocks/line, 14 lines/frame) so many frames fit in a short run.
module tb_vga_timing_receiver;

  localparam int HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int HP = HS + HB + HA + HF + 1;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int VP = VS + VB + VA + VF + 1;
  localparam int XB = HS + HB;
  localparam int YB = VS + VB;

  logic        clk = 1'b0;
  logic        iRST;
  logic        iVGA_H_SYNC, iVGA_V_SYNC;
  logic [9:0]  iVGA_R, iVGA_G, iVGA_B;
  logic [9:0]  oCoord_X, oCoord_Y, oR, oG, oB;
  logic        oPix_Valid, oFrame_Start, oLocked, oErr;
  logic [10:0] oLine_Period, oFrame_Lines;
  logic [1:0]  oDbg_State;

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .H_SYNC_CYC(HS), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA),
    .V_SYNC_CYC(VS), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA),
    .H_PERIOD(HP), .V_PERIOD(VP), .H_TOL(1), .LOCK_FRAMES(2)
  ) dut (
    .iCLK(clk), .iRST(iRST),
    .iVGA_H_SYNC(iVGA_H_SYNC), .iVGA_V_SYNC(iVGA_V_SYNC),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y), .oPix_Valid(oPix_Valid),
    .oR(oR), .oG(oG), .oB(oB),
    .oFrame_Start(oFrame_Start), .oLocked(oLocked), .oErr(oErr),
    .oLine_Period(oLine_Period), .oFrame_Lines(oFrame_Lines),
    .oDbg_State(oDbg_State)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Expected pixel pipeline: index 0 = last driven, index 1 = the one due at the outputs now.
  logic       ev [0:1];
  logic [9:0] ex [0:1], ey [0:1], er [0:1], eg [0:1], eb [0:1];
  logic       exp_lock, score_en, prev_locked;
  int         sb_bad, fv_cnt, err_cnt, err_cyc, fs_cnt, fs_cyc, rise_cyc, fall_cyc, f_cyc;
  int         ls_cyc [0:15];
  logic [9:0] first_x, first_y, first_r, last_x, last_y, last_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_coord"}, 32'({oCoord_X, oCoord_Y}), 32'd0);
    check({tag, "_rgb"},   32'({oR, oG, oB}), 32'd0);
    check({tag, "_flags"}, 32'({oPix_Valid, oFrame_Start, oLocked, oErr}), 32'd0);
    check({tag, "_meas"},  32'({oLine_Period, oFrame_Lines}), 32'd0);
    check({tag, "_state"}, 32'(oDbg_State), 32'd0);
  endtask

  // One clock: observe outputs, then drive the next pixel.
  task automatic drive(input logic h_s, input logic v_s, input logic [9:0] pr, input logic [9:0] pg,
                       input logic [9:0] pb, input logic pv, input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    cyc++;
    if (oPix_Valid) begin
      if (fv_cnt == 0) begin
        first_x = oCoord_X; first_y = oCoord_Y; first_r = oR;
      end
      last_x = oCoord_X; last_y = oCoord_Y; last_r = oR;
      fv_cnt++;
    end
    if (oErr) begin err_cnt++; err_cyc = cyc; end
    if (oFrame_Start) begin fs_cnt++; fs_cyc = cyc; end
    if (oLocked && !prev_locked) rise_cyc = cyc;
    if (!oLocked && prev_locked) fall_cyc = cyc;
    prev_locked = oLocked;
    if (score_en) begin
      if (oPix_Valid !== ev[1] || oR !== er[1] || oG !== eg[1] || oB !== eb[1]) sb_bad++;
      else if (ev[1] && (oCoord_X !== ex[1] || oCoord_Y !== ey[1])) sb_bad++;
    end
    ev[1] = ev[0]; ex[1] = ex[0]; ey[1] = ey[0]; er[1] = er[0]; eg[1] = eg[0]; eb[1] = eb[0];
    ev[0] = pv; ex[0] = px; ey[0] = py;
    er[0] = pv ? pr : 10'd0;
    eg[0] = pv ? pg : 10'd0;
    eb[0] = pv ? pb : 10'd0;
    iVGA_H_SYNC = h_s;
    iVGA_V_SYNC = v_s;
    iVGA_R = pr;
    iVGA_G = pg;
    iVGA_B = pb;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 10'd0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic send_line(input int v, input int len, input int rst_h);
    logic act;
    for (int h = 0; h < len; h++) begin
      act = (h >= XB) && (h < XB + HA) && (v >= YB) && (v < YB + VA);
      drive(h >= HS, v >= VS, 10'(h - XB), 10'(v), 10'(h * 3 + v),
            exp_lock && act, 10'(h - XB), 10'(v - YB));
      if (h == 0) begin
        ls_cyc[v] = cyc;
        if (v == 0) f_cyc = cyc;
      end
      if (rst_h >= 0 && h == rst_h + 1) check_zero("midline_reset");
      iRST = (h == rst_h);
    end
  endtask

  task automatic send_frame(input int lines, input int bad_v, input int bad_len,
                            input int rst_v, input int rst_h);
    for (int v = 0; v < lines; v++)
      send_line(v, (v == bad_v) ? bad_len : HP, (v == rst_v) ? rst_h : -1);
  endtask

  initial begin
    iRST = 1'b1;
    iVGA_H_SYNC = 1'b1; iVGA_V_SYNC = 1'b1;
    iVGA_R = '0; iVGA_G = '0; iVGA_B = '0;
    exp_lock = 1'b0; score_en = 1'b0; prev_locked = 1'b0;
    sb_bad = 0; fv_cnt = 0; err_cnt = 0; err_cyc = -1; fs_cnt = 0; fs_cyc = -1;
    rise_cyc = -1; fall_cyc = -1; f_cyc = -1;
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b0; ex[i] = '0; ey[i] = '0; er[i] = '0; eg[i] = '0; eb[i] = '0;
    end
    for (int i = 0; i < 16; i++) ls_cyc[i] = -1;

    // Reset state, then nominal lock after SEARCH + 2 good frames
    repeat (4) idle();
    check_zero("reset");
    iRST = 1'b0;
    send_frame(VP, -1, 0, -1, -1);
    send_frame(VP, -1, 0, -1, -1);
    check("unlocked_after_2nd_vfall", 32'(oLocked), 32'd0);
    exp_lock = 1'b1; score_en = 1'b1; fv_cnt = 0;
    send_frame(VP, -1, 0, -1, -1);
    check("lock_rise_cycle", 32'(rise_cyc), 32'(f_cyc + 2));
    check("line_period", 32'(oLine_Period), 32'(HP));
    check("frame_lines", 32'(oFrame_Lines), 32'(VP));
    check("valid_count_f3", 32'(fv_cnt), 32'(HA * VA));
    check("first_x", 32'(first_x), 32'd0);
    check("first_y", 32'(first_y), 32'd0);
    check("first_r", 32'(first_r), 32'd0);
    check("last_x", 32'(last_x), 32'(HA - 1));
    check("last_y", 32'(last_y), 32'(VA - 1));
    check("last_r", 32'(last_r), 32'(HA - 1));

    fv_cnt = 0; fs_cnt = 0;
    send_frame(VP, -1, 0, -1, -1);
    check("frame_start_count", 32'(fs_cnt), 32'd1);
    check("frame_start_cycle", 32'(fs_cyc), 32'(f_cyc + 2));
    check("valid_count_f4", 32'(fv_cnt), 32'(HA * VA));

    // One line one clock long: inside tolerance
    for (int v = 0; v < VP; v++) begin
      send_line(v, (v == 2) ? HP + 1 : HP, -1);
      if (v == 3) check("line_period_long_ok", 32'(oLine_Period), 32'(HP + 1));
    end
    check("no_err_within_tol", 32'(err_cnt), 32'd0);
    check("lock_held_within_tol", 32'(oLocked), 32'd1);
    check("pix_scoreboard_locked", 32'(sb_bad), 32'd0);

    // One line two clocks long: error, unlock, relock after 3 vfalls
    score_en = 1'b0; exp_lock = 1'b0;
    send_frame(VP, 3, HP + 2, -1, -1);
    check("err_pulse_count", 32'(err_cnt), 32'd1);
    check("err_cycle", 32'(err_cyc), 32'(ls_cyc[4] + 2));
    check("unlock_after_err", 32'(fall_cyc), 32'(err_cyc + 1));
    check("unlocked_after_err", 32'(oLocked), 32'd0);
    send_frame(VP, -1, 0, -1, -1);
    send_frame(VP, -1, 0, -1, -1);
    check("no_early_relock", 32'(oLocked), 32'd0);
    exp_lock = 1'b1; score_en = 1'b1;
    send_frame(VP, -1, 0, -1, -1);
    check("relock_cycle", 32'(rise_cyc), 32'(f_cyc + 2));
    check("err_total", 32'(err_cnt), 32'd1);
    check("pix_scoreboard_relock", 32'(sb_bad), 32'd0);

    // Reset mid active line while locked, then relock
    score_en = 1'b0; exp_lock = 1'b0;
    send_frame(VP, -1, 0, 6, 10);
    send_frame(VP, -1, 0, -1, -1);
    send_frame(VP, -1, 0, -1, -1);
    check("no_lock_soon_after_reset", 32'(oLocked), 32'd0);
    send_frame(VP, -1, 0, -1, -1);
    check("relock_after_reset", 32'(rise_cyc), 32'(f_cyc + 2));

    // Short frame while measuring clears the good-frame count
    iRST = 1'b1;
    repeat (3) idle();
    iRST = 1'b0;
    send_frame(VP, -1, 0, -1, -1);
    send_frame(VP - 1, -1, 0, -1, -1);
    send_frame(VP, -1, 0, -1, -1);
    check("short_frame_lines", 32'(oFrame_Lines), 32'(VP - 1));
    check("no_lock_after_short", 32'(oLocked), 32'd0);
    send_frame(VP, -1, 0, -1, -1);
    check("good_count_cleared", 32'(oLocked), 32'd0);
    send_frame(VP, -1, 0, -1, -1);
    check("lock_after_short", 32'(rise_cyc), 32'(f_cyc + 2));
    check("locked_final", 32'(oLocked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
